// File: rtl/ssi_gate_sweep_if.sv
// Control, operand and status bundle for ssi_gate_sweep.
// The tri-stated per-lane result stays a plain module port.
interface ssi_gate_sweep_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [31:0]      tt;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, tt, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, tt, err
  );
endinterface

// File: rtl/ssi_gate_sweep.sv
// Registered N-lane SSI gate datapath with a built-in truth-table sweep self-test.
// The sweep drives every op over all four input pairs and checks a 32-bit signature.
module ssi_gate_sweep #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  ssi_gate_sweep_if.slave  bus,
  output wire [WIDTH-1:0]  out
);

  localparam int unsigned   HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HoldLast  = HW'(HOLD_CYCLES - 1);
  localparam logic [31:0]   Golden    = 32'h8961_75E8;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       step_q, step_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [31:0]      tt_q, tt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] en_q, en_d;

  logic [2:0]       op_s;
  logic [WIDTH-1:0] a_s, b_s;
  logic             capture;
  logic             lane0;
  logic             lane_bad;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StSweep;
      StSweep: if (capture && (step_q == 5'd31)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state_q == StSweep);
    bus.done = (state_q == StDone);
  end

  // During a sweep the step index itself is the stimulus: op = step[4:2], B = step[1], A = step[0].
  always_comb begin
    op_s = bus.op;
    a_s  = bus.a;
    b_s  = bus.b;
    if (state_q == StSweep) begin
      op_s = step_q[4:2];
      a_s  = {WIDTH{step_q[0]}};
      b_s  = {WIDTH{step_q[1]}};
    end
  end

  always_comb begin
    y_d  = '0;
    en_d = '1;
    for (int i = 0; i < WIDTH; i++) begin
      case (op_s)
        3'd0:    y_d[i] = a_s[i] & b_s[i];
        3'd1:    y_d[i] = a_s[i] | b_s[i];
        3'd2:    y_d[i] = ~a_s[i];
        3'd3:    y_d[i] = ~(a_s[i] & b_s[i]);
        3'd4:    y_d[i] = ~(a_s[i] | b_s[i]);
        3'd5:    y_d[i] = a_s[i] ^ b_s[i];
        3'd6:    y_d[i] = ~(a_s[i] ^ b_s[i]);
        default: y_d[i] = a_s[i];
      endcase
    end
    if (op_s == 3'd7) en_d = b_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q  <= '0;
      en_q <= '1;
    end else begin
      y_q  <= y_d;
      en_q <= en_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign out[i] = en_q[i] ? y_q[i] : 1'bz;
  end

  // A disabled lane reads as 0, both for the signature and for lane agreement.
  assign lane0    = en_q[0] & y_q[0];
  assign lane_bad = |((en_q & y_q) ^ {WIDTH{lane0}});
  assign capture  = (state_q == StSweep) && (hold_q == HoldLast);

  always_comb begin
    step_d = step_q;
    hold_d = hold_q;
    tt_d   = tt_q;
    err_d  = err_q;
    if ((state_q == StIdle) && bus.start) begin
      step_d = '0;
      hold_d = '0;
      tt_d   = '0;
      err_d  = 1'b0;
    end else if (state_q == StSweep) begin
      if (capture) begin
        hold_d       = '0;
        step_d       = step_q + 5'd1;
        tt_d[step_q] = lane0;
        if (lane_bad || (lane0 != Golden[step_q])) err_d = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      hold_q <= '0;
      tt_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      hold_q <= hold_d;
      tt_q   <= tt_d;
      err_q  <= err_d;
    end
  end

  assign bus.tt  = tt_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_ssi_gate_sweep.sv
// Self-checking bench for ssi_gate_sweep: direct gate ops against a vector model, then
// full sweeps (nominal, lane fault, mid-sweep reset, back-to-back) against a modelled signature.
module tb_ssi_gate_sweep;
  localparam int unsigned W = 4;
  localparam int unsigned H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tri [W-1:0] out;

  ssi_gate_sweep_if #(.WIDTH(W)) bus ();

  ssi_gate_sweep #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .out (out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Whole-vector gate semantics; TRI lanes with B=0 float.
  function automatic logic [W-1:0] model_out(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~a;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: for (int i = 0; i < W; i++) r[i] = b[i] ? a[i] : 1'bz;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts cycles BUSY is observed high; bounded so a stuck DUT still reaches the summary.
  task automatic wait_sweep(input bit extra_starts, output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      if (extra_starts) bus.start = (n == 50 || n == 100);
      tick;
    end
  endtask

  logic [31:0]  exp_tt;
  logic         exp_fault_err;
  logic [W-1:0] o;
  logic [W-1:0] ra, rb;
  logic [2:0]   rop;
  logic [4:0]   st;
  int           n;

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;

    // Expected signature and fault outcome derived from the gate semantics alone.
    exp_tt        = '0;
    exp_fault_err = 1'b0;
    for (int s = 0; s < 32; s++) begin
      st = s[4:0];
      o  = model_out(st[4:2], {W{st[0]}}, {W{st[1]}});
      exp_tt[s] = (o[0] === 1'b1);
      // A lane stuck at 1 disagrees with lane 0 whenever lane 0 is enabled and low.
      if (((st[4:2] != 3'd7) || st[1]) && (o[0] !== 1'b1)) exp_fault_err = 1'b1;
    end

    #12 rst = 1'b0;

    // Asynchronous reset mid-cycle
    bus.op = 3'd1; bus.a = 4'hF; bus.b = 4'h0;
    tick;
    check("pre_reset_out", {28'd0, out}, 32'h0000_000F);
    #3 rst = 1'b1;
    #1;
    check("rst_out",  {28'd0, out}, 32'd0);
    check("rst_tt",   bus.tt, 32'd0);
    check("rst_err",  {31'd0, bus.err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    #1 rst = 1'b0;

    // Direct ops on the reference pattern, then random operands
    for (int k = 0; k < 8; k++) begin
      bus.op = 3'(k); bus.a = 4'b0101; bus.b = 4'b0011;
      tick;
      check($sformatf("direct_op%0d", k), {28'd0, out}, {28'd0, model_out(3'(k), 4'b0101, 4'b0011)});
    end
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 7)); ra = 4'($urandom); rb = 4'($urandom);
      bus.op = rop; bus.a = ra; bus.b = rb;
      tick;
      check($sformatf("rand_op%0d", rop), {28'd0, out}, {28'd0, model_out(rop, ra, rb)});
    end

    // Nominal sweep with extra START pulses while busy
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("sweep1_busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_sweep(1'b1, n);
    bus.start = 1'b0;
    check("sweep1_busy_len", n, H * 32);
    check("sweep1_done", {31'd0, bus.done}, 32'd1);
    check("sweep1_tt", bus.tt, exp_tt);
    check("sweep1_err", {31'd0, bus.err}, 32'd0);
    tick;
    check("sweep1_done_fall", {30'd0, bus.done, bus.busy}, 32'd0);
    tick;
    tick;
    check("sweep1_no_retrigger", {30'd0, bus.done, bus.busy}, 32'd0);

    // Results hold while direct ops run
    for (int k = 0; k < 4; k++) begin
      bus.op = 3'($urandom_range(0, 7)); bus.a = 4'($urandom); bus.b = 4'($urandom);
      tick;
    end
    check("hold_tt", bus.tt, exp_tt);
    check("hold_err", {31'd0, bus.err}, 32'd0);

    // Lane 2 stuck at 1
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    force dut.y_q[2] = 1'b1;
    wait_sweep(1'b0, n);
    release dut.y_q[2];
    check("fault_busy_len", n, H * 32);
    check("fault_err", {31'd0, bus.err}, {31'd0, exp_fault_err});
    check("fault_tt", bus.tt, exp_tt);
    tick;

    // Reset during step 17
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("abort_err_clear", {31'd0, bus.err}, 32'd0);
    n = 0;
    while (bus.busy && n < 175) begin
      n++;
      tick;
    end
    check("abort_reached", n, 175);
    check("abort_partial_tt", bus.tt, exp_tt & 32'h0001_FFFF);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_tt", bus.tt, 32'd0);
    #1 rst = 1'b0;
    tick;
    tick;
    check("abort_no_done", {30'd0, bus.done, bus.busy}, 32'd0);

    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    wait_sweep(1'b0, n);
    check("post_abort_len", n, H * 32);
    check("post_abort_done", {31'd0, bus.done}, 32'd1);
    check("post_abort_tt", bus.tt, exp_tt);
    check("post_abort_err", {31'd0, bus.err}, 32'd0);
    tick;

    // Back-to-back with START held
    bus.start = 1'b1;
    tick;
    wait_sweep(1'b0, n);
    check("b2b_len1", n, H * 32);
    check("b2b_done1", {31'd0, bus.done}, 32'd1);
    tick;
    check("b2b_idle_gap", {30'd0, bus.done, bus.busy}, 32'd0);
    tick;
    check("b2b_busy_rerise", {31'd0, bus.busy}, 32'd1);
    check("b2b_tt_cleared", bus.tt, 32'd0);
    bus.start = 1'b0;
    wait_sweep(1'b0, n);
    check("b2b_len2", n, H * 32);
    check("b2b_done2", {31'd0, bus.done}, 32'd1);
    check("b2b_tt", bus.tt, exp_tt);
    check("b2b_err", {31'd0, bus.err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssi_gate_sweep.md
# ssi_gate_sweep

Parametrised, registered N-lane successor to the SSI gate library: one shared opcode selects AND/OR/NOT/NAND/NOR/XOR/XNOR/TRI across WIDTH lanes. On START, a built-in sequencer sweeps all 8 ops × 4 input combinations and captures a 32-bit truth-table signature. It checks that signature against the golden value and checks lane agreement. It sits beside the combinational gate library as its registered datapath and power-on self-test.

## Interface
- WIDTH, 4, lane count (≥1)
- HOLD_CYCLES, 10, cycles each sweep step is held (≥2)
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  level-sampled; starts sweep when in IDLE
- OP  in  3  opcode: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 TRI (A when B=1, else Z)
- A  in  WIDTH  operand A per lane
- B  in  WIDTH  operand B per lane (TRI enable for op 7)
- OUT  out  WIDTH  per-lane result; lane i is high-Z when its enable register is 0
- BUSY  out  1  high in SWEEP
- DONE  out  1  one-cycle pulse at sweep end
- TT  out  32  captured truth table, bit index op*4+c
- ERR  out  1  sticky sweep failure flag

## Operation
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
- Datapath: registers Y[WIDTH] and EN[WIDTH]. Every cycle, for each lane i, Y[i] <= f(op, a_i, b_i). EN[i] <= (op==7) ? b_i : 1. OUT[i] = EN[i] ? Y[i] : Z.
- For op 7, Y[i] <= a_i.
- Operand source: IDLE and DONE use external OP/A/B. SWEEP uses internal op=step[4:2], A lanes all = step[0], B lanes all = step[1].
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when START=1. On that edge: step<=0, hold<=0, TT<=0, ERR<=0.
  - SWEEP: hold increments each cycle. When hold==HOLD_CYCLES-1, capture: TT[step] <= EN[0] & Y[0], with Z counted as 0. Then hold<=0 and step<=step+1.
  - SWEEP -> DONE on the capture at step 31.
  - DONE -> IDLE unconditionally after 1 cycle.
- START is ignored in SWEEP and DONE. A START held high re-triggers from IDLE, giving back-to-back sweeps with one IDLE cycle between.
- ERR is set at a capture if any lane i has (EN[i]&Y[i]) != (EN[0]&Y[0]), or if the captured bit differs from GOLDEN[step].
- GOLDEN = 32'h8961_75E8.
- ERR is cleared only by reset or by a new START.
- TT and ERR hold their values after DONE until the next START or reset.
- External A/B/OP are ignored during SWEEP; OUT shows the sweep stimulus results.

## Timing
- Reset values: state IDLE, Y=0, EN=all 1 (OUT=0), TT=0, ERR=0, BUSY=0, DONE=0, step=0, hold=0.
- Reset asserted mid-sweep aborts immediately to these values; no DONE pulse.
- Direct mode latency: 1 cycle (inputs at edge k -> OUT after edge k).
- BUSY rises on the edge that samples START. It stays high for exactly 32*HOLD_CYCLES cycles.
- DONE is high for the single cycle after BUSY falls. Start-sample edge to DONE-rise edge = 32*HOLD_CYCLES + 1 edges... DONE rises on edge 32*HOLD_CYCLES.
- Capture samples Y registered at least one cycle after the stimulus changed. HOLD_CYCLES≥2 guarantees settled data.
- step is 5 bits and never wraps inside a sweep; the step-31 capture exits SWEEP.

## Test plan
- Reset: assert RST asynchronously mid-cycle -> OUT=0, TT=0, ERR=0, BUSY=0, DONE=0 without a clock edge.
- Direct ops, WIDTH=4:
  - A=4'b0101, B=4'b0011, OP=0..6 -> one cycle later OUT = 0001, 0111, 1010, 1110, 1000, 0110, 1001.
  - OP=7 -> OUT=4'bzz01.
- Full sweep, HOLD_CYCLES=10: pulse START -> BUSY high 320 cycles, DONE pulses once, TT=32'h896175E8, ERR=0.
- Lane fault: force Y[2] to 1 during sweep (inject) -> ERR=1 after DONE; TT unchanged (lane 0 good).
- START during SWEEP and a reset at step 17: extra START pulses ignored (single DONE). Reset at step 17 -> BUSY=0, TT=0, no DONE; a subsequent START completes normally.
- Back-to-back: hold START high -> DONE, one IDLE cycle, BUSY re-rises. TT/ERR are cleared at the restart and end equal to the golden signature.
